// File: rtl/scc_pkg.sv
// Shared SCC wave-table constants, bus payload types and the CPU buffer state encoding.
package scc_pkg;

  localparam int unsigned SCC_NUM_CH     = 5;
  localparam int unsigned SCC_SLOTS      = 8;
  localparam int unsigned SCC_SLOT_W     = 3;
  localparam int unsigned SCC_WAVE_DEPTH = 160;
  localparam int unsigned SCC_FREQ_W     = 12;
  localparam int unsigned SCC_PTR_W      = 5;
  localparam int unsigned SCC_ADDR_W     = 8;
  localparam int unsigned SCC_DATA_W     = 8;

  typedef logic [SCC_SLOT_W-1:0] scc_slot_t;

  typedef enum logic [1:0] {
    CPU_IDLE = 2'd0,
    CPU_FULL = 2'd1,
    CPU_RD_A = 2'd2,
    CPU_RD_Q = 2'd3
  } scc_cpu_st_e;

  typedef struct packed {
    logic                  wr;
    logic [SCC_ADDR_W-1:0] addr;
    logic [SCC_DATA_W-1:0] wdata;
  } scc_cpu_req_t;

  // Wave RAM only backs the first SCC_WAVE_DEPTH bytes of the CPU window.
  function automatic logic scc_addr_ok(input logic [SCC_ADDR_W-1:0] addr);
    return addr < SCC_ADDR_W'(SCC_WAVE_DEPTH);
  endfunction

endpackage

// File: rtl/scc_wave_sram_sequencer_if.sv
// CPU wave-RAM access port: request held until accepted, read data returned as a pulse.
interface scc_wave_sram_sequencer_if;
  import scc_pkg::*;

  logic                  cpu_req;
  logic                  cpu_wr;
  logic [SCC_ADDR_W-1:0] cpu_addr;
  logic [SCC_DATA_W-1:0] cpu_wdata;
  logic                  cpu_ready;
  logic                  cpu_rvalid;
  logic [SCC_DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rvalid, cpu_rdata
  );

endinterface

// File: rtl/scc_tone_counter.sv
// One SCC tone channel: period register, reload down-counter and 5-bit wave pointer.
module scc_tone_counter
  import scc_pkg::*;
#(
  parameter int unsigned FREQ_W = SCC_FREQ_W,
  parameter int unsigned PTR_W  = SCC_PTR_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              en_i,
  input  logic              key_on_i,
  input  logic              freq_we_i,
  input  logic [FREQ_W-1:0] freq_data_i,
  output logic [PTR_W-1:0]  ptr_o
);

  logic [FREQ_W-1:0] period_q;
  logic [FREQ_W-1:0] cnt_q;
  logic [PTR_W-1:0]  ptr_q;

  // A period write never touches the running count; a reload in the same cycle sees the old period.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      period_q <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
    end else begin
      if (freq_we_i) begin
        period_q <= freq_data_i;
      end
      if (en_i) begin
        if (!key_on_i) begin
          ptr_q <= '0;
          cnt_q <= period_q;
        end else if (cnt_q == '0) begin
          cnt_q <= period_q;
          ptr_q <= ptr_q + PTR_W'(1);
        end else begin
          cnt_q <= cnt_q - FREQ_W'(1);
        end
      end
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/scc_wave_sram_sequencer.sv
// SCC wave-table SRAM port owner: channel sample slots interleaved with a single-entry
// CPU access buffer served in the spare slots of each 8-slot round.
module scc_wave_sram_sequencer
  import scc_pkg::*;
#(
  parameter int unsigned NUM_CH = SCC_NUM_CH,
  parameter int unsigned FREQ_W = SCC_FREQ_W,
  parameter int unsigned PTR_W  = SCC_PTR_W
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   reg_freq_we,
  input  logic [SCC_SLOT_W-1:0]  reg_freq_ch,
  input  logic [FREQ_W-1:0]      reg_freq_data,
  input  logic [NUM_CH-1:0]      reg_key_on,
  scc_wave_sram_sequencer_if.slave cpu,
  output logic [SCC_ADDR_W-1:0]  sram_a,
  output logic                   sram_we,
  output logic [SCC_DATA_W-1:0]  sram_d,
  input  logic [SCC_DATA_W-1:0]  sram_q,
  output logic                   smp_valid,
  output logic [SCC_SLOT_W-1:0]  smp_ch
);

  scc_slot_t             slot_q;
  scc_cpu_st_e           st_q;
  scc_cpu_req_t          buf_q;
  logic                  iss_q;
  scc_slot_t             iss_ch_q;
  logic [SCC_ADDR_W-1:0] sram_a_q;
  logic                  sram_we_q;
  logic [SCC_DATA_W-1:0] sram_d_q;
  logic                  smp_valid_q;
  scc_slot_t             smp_ch_q;
  logic                  cpu_ready_q;
  logic                  cpu_rvalid_q;
  logic [SCC_DATA_W-1:0] cpu_rdata_q;

  logic                  chan_slot;
  logic                  buf_addr_ok;
  logic [PTR_W-1:0]      cur_ptr;
  logic [PTR_W-1:0]      ptr [NUM_CH];

  assign chan_slot   = 32'(slot_q) < NUM_CH;
  assign buf_addr_ok = scc_addr_ok(buf_q.addr);

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    scc_tone_counter #(
      .FREQ_W (FREQ_W),
      .PTR_W  (PTR_W)
    ) u_tone (
      .clk         (clk),
      .nreset      (nreset),
      .en_i        (slot_q == SCC_SLOT_W'(g)),
      .key_on_i    (reg_key_on[g]),
      .freq_we_i   (reg_freq_we && (reg_freq_ch == SCC_SLOT_W'(g))),
      .freq_data_i (reg_freq_data),
      .ptr_o       (ptr[g])
    );
  end

  // Pointer of the channel owning the current slot, sampled before its update.
  always_comb begin
    cur_ptr = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (slot_q == SCC_SLOT_W'(i)) begin
        cur_ptr = ptr[i];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot_q       <= '0;
      st_q         <= CPU_IDLE;
      buf_q        <= '0;
      iss_q        <= 1'b0;
      iss_ch_q     <= '0;
      sram_a_q     <= '0;
      sram_we_q    <= 1'b0;
      sram_d_q     <= '0;
      smp_valid_q  <= 1'b0;
      smp_ch_q     <= '0;
      cpu_ready_q  <= 1'b1;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      slot_q       <= slot_q + SCC_SLOT_W'(1);
      sram_we_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      iss_q        <= chan_slot;
      smp_valid_q  <= iss_q;
      smp_ch_q     <= iss_ch_q;

      // Out-of-range CPU accesses leave the SRAM port untouched.
      if (chan_slot) begin
        iss_ch_q <= slot_q;
        sram_a_q <= SCC_ADDR_W'({slot_q, cur_ptr});
      end else if ((st_q == CPU_FULL) && buf_addr_ok) begin
        sram_a_q  <= buf_q.addr;
        sram_we_q <= buf_q.wr;
        sram_d_q  <= buf_q.wdata;
      end

      case (st_q)
        CPU_IDLE: begin
          if (cpu.cpu_req) begin
            buf_q       <= '{wr: cpu.cpu_wr, addr: cpu.cpu_addr, wdata: cpu.cpu_wdata};
            st_q        <= CPU_FULL;
            cpu_ready_q <= 1'b0;
          end
        end
        CPU_FULL: begin
          if (!chan_slot) begin
            if (buf_q.wr) begin
              st_q        <= CPU_IDLE;
              cpu_ready_q <= 1'b1;
            end else begin
              st_q <= CPU_RD_A;
            end
          end
        end
        CPU_RD_A: st_q <= CPU_RD_Q;
        CPU_RD_Q: begin
          st_q         <= CPU_IDLE;
          cpu_ready_q  <= 1'b1;
          cpu_rvalid_q <= 1'b1;
          cpu_rdata_q  <= buf_addr_ok ? sram_q : '0;
        end
        default: st_q <= CPU_IDLE;
      endcase
    end
  end

  assign sram_a         = sram_a_q;
  assign sram_we        = sram_we_q;
  assign sram_d         = sram_d_q;
  assign smp_valid      = smp_valid_q;
  assign smp_ch         = smp_ch_q;
  assign cpu.cpu_ready  = cpu_ready_q;
  assign cpu.cpu_rvalid = cpu_rvalid_q;
  assign cpu.cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_scc_wave_sram_sequencer.sv
// Bench for scc_wave_sram_sequencer: behavioural slot/channel/CPU model plus a simple SRAM.
`timescale 1ns/1ps
module tb_scc_wave_sram_sequencer;
  import scc_pkg::*;

  localparam int NCH = 5;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        reg_freq_we;
  logic [2:0]  reg_freq_ch;
  logic [11:0] reg_freq_data;
  logic [4:0]  reg_key_on;
  logic [7:0]  sram_a, sram_d, sram_q;
  logic        sram_we, smp_valid;
  logic [2:0]  smp_ch;

  always #5 clk = ~clk;

  scc_wave_sram_sequencer_if cpu_if ();

  scc_wave_sram_sequencer dut (
    .clk           (clk),
    .nreset        (nreset),
    .reg_freq_we   (reg_freq_we),
    .reg_freq_ch   (reg_freq_ch),
    .reg_freq_data (reg_freq_data),
    .reg_key_on    (reg_key_on),
    .cpu           (cpu_if.slave),
    .sram_a        (sram_a),
    .sram_we       (sram_we),
    .sram_d        (sram_d),
    .sram_q        (sram_q),
    .smp_valid     (smp_valid),
    .smp_ch        (smp_ch)
  );

  // Synchronous SRAM: read data one clock after the address, read-before-write.
  logic [7:0] mem [256];
  logic [7:0] init_val [256];
  logic       mem_load;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val[i];
    end else begin
      sram_q <= mem[sram_a];
      if (sram_we) mem[sram_a] <= sram_d;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int  m_slot, m_period[NCH], m_cnt[NCH], m_ptr[NCH];
  bit  m_pend, m_wr;
  int  m_addr, m_wdata, m_rd_stage, m_rd_val;
  bit  m_iss;
  int  m_iss_ch, m_iss_val;
  int  ref_mem[256];
  int  e_sram_a, e_sram_d, e_rdata, e_smp_ch, e_smp_val;
  bit  e_we, e_smp_valid, e_ready, e_rvalid;

  // Stimulus state
  bit           st_fwe;
  int           st_fch, st_fdata;
  logic [4:0]   st_key;
  scc_cpu_req_t cpu_q[$];
  scc_cpu_req_t cur;
  bit           req_active;

  task automatic model_reset();
    m_slot = 0; m_pend = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
    m_rd_stage = 0; m_rd_val = 0; m_iss = 0; m_iss_ch = 0; m_iss_val = 0;
    for (int i = 0; i < NCH; i++) begin m_period[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0; end
    e_sram_a = 0; e_sram_d = 0; e_rdata = 0; e_smp_ch = 0; e_smp_val = 0;
    e_we = 0; e_smp_valid = 0; e_ready = 1; e_rvalid = 0;
  endtask

  // Advance the model across one rising edge given the inputs presented before it.
  task automatic model_step(output bit acc);
    int k;
    acc = req_active && e_ready;
    e_smp_valid = m_iss; e_smp_ch = m_iss_ch; e_smp_val = m_iss_val;
    e_we = 0; e_rvalid = 0; m_iss = 0;
    if (m_rd_stage == 2) begin
      e_rvalid = 1; e_rdata = m_rd_val; m_pend = 0; m_rd_stage = 0;
    end else if (m_rd_stage == 1) begin
      m_rd_stage = 2;
    end
    if (m_slot < NCH) begin
      k = m_slot;
      e_sram_a = k * 32 + m_ptr[k];
      m_iss = 1; m_iss_ch = k; m_iss_val = ref_mem[e_sram_a];
      if (!st_key[k]) begin m_ptr[k] = 0; m_cnt[k] = m_period[k]; end
      else if (m_cnt[k] == 0) begin m_cnt[k] = m_period[k]; m_ptr[k] = (m_ptr[k] + 1) % 32; end
      else m_cnt[k] = m_cnt[k] - 1;
    end else if (m_pend && m_rd_stage == 0) begin
      if (m_addr < 160) begin e_sram_a = m_addr; e_sram_d = m_wdata; e_we = m_wr; end
      if (m_wr) begin
        if (m_addr < 160) ref_mem[m_addr] = m_wdata;
        m_pend = 0;
      end else begin
        m_rd_stage = 1;
        m_rd_val = (m_addr < 160) ? ref_mem[m_addr] : 0;
      end
    end
    if (st_fwe && st_fch < NCH) m_period[st_fch] = st_fdata;
    if (acc) begin m_pend = 1; m_wr = cur.wr; m_addr = cur.addr; m_wdata = cur.wdata; end
    e_ready = !m_pend;
    m_slot = (m_slot + 1) % 8;
  endtask

  task automatic do_checks();
    check("sram_a", sram_a, e_sram_a);
    check("sram_we", sram_we, e_we);
    check("sram_d", sram_d, e_sram_d);
    check("smp_valid", smp_valid, e_smp_valid);
    if (e_smp_valid) begin
      check("smp_ch", smp_ch, e_smp_ch);
      check("smp_data", sram_q, e_smp_val);
    end
    check("cpu_ready", cpu_if.cpu_ready, e_ready);
    check("cpu_rvalid", cpu_if.cpu_rvalid, e_rvalid);
    check("cpu_rdata", cpu_if.cpu_rdata, e_rdata);
  endtask

  // Called at a falling edge: check outputs, drive inputs, step the model, move to next falling edge.
  task automatic run_cycle();
    bit acc;
    do_checks();
    if (!req_active && cpu_q.size() > 0) begin cur = cpu_q.pop_front(); req_active = 1; end
    cpu_if.cpu_req   = req_active;
    cpu_if.cpu_wr    = cur.wr;
    cpu_if.cpu_addr  = cur.addr;
    cpu_if.cpu_wdata = cur.wdata;
    reg_freq_we   = st_fwe;
    reg_freq_ch   = 3'(st_fch);
    reg_freq_data = 12'(st_fdata);
    reg_key_on    = st_key;
    model_step(acc);
    if (acc) req_active = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic freq_write(input int ch, input int data);
    st_fwe = 1; st_fch = ch; st_fdata = data;
    run_cycle();
    st_fwe = 0;
  endtask

  task automatic cpu_push(input bit wr, input int addr, input int data);
    cpu_q.push_back('{wr: wr, addr: 8'(addr), wdata: 8'(data)});
  endtask

  initial begin
    int waited;
    for (int i = 0; i < 256; i++) begin
      init_val[i] = 8'($urandom);
      ref_mem[i]  = init_val[i];
    end
    mem_load = 1;
    st_fwe = 0; st_fch = 0; st_fdata = 0; st_key = '0; req_active = 0; cur = '0;
    reg_freq_we = 0; reg_freq_ch = 0; reg_freq_data = 0; reg_key_on = 0;
    cpu_if.cpu_req = 0; cpu_if.cpu_wr = 0; cpu_if.cpu_addr = 0; cpu_if.cpu_wdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    do_checks();
    mem_load = 0;
    nreset = 1;

    // Reset release: channel addresses 0,32,64,96,128 then the CPU slots
    repeat (24) run_cycle();

    // ch0 period 2 and ch3 period 0 with key on, long enough for ch3 to wrap
    freq_write(0, 2);
    freq_write(3, 0);
    freq_write(6, 9);
    st_key = 5'b01001;
    repeat (8 * 40) run_cycle();

    // CPU write then ch1 sweeps through the written byte
    freq_write(1, 0);
    cpu_push(1, 37, 8'hA5);
    st_key = 5'b00010;
    repeat (8 * 12) run_cycle();

    // Out-of-range read/write, in-range read back, key off
    cpu_push(0, 200, 0);
    cpu_push(0, 37, 0);
    cpu_push(1, 250, 8'h3C);
    cpu_push(0, 159, 0);
    st_key = '0;
    repeat (80) run_cycle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        st_fwe = 1; st_fch = $urandom_range(0, 7);
        st_fdata = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 3);
      end
      if ($urandom_range(0, 63) == 0) st_key = 5'($urandom);
      if (cpu_q.size() == 0 && $urandom_range(0, 3) == 0)
        cpu_push(1'($urandom), ($urandom_range(0, 9) == 0) ? $urandom_range(160, 255) : $urandom_range(0, 159),
                 $urandom_range(0, 255));
      run_cycle();
      st_fwe = 0;
    end

    // Reset while the CPU buffer holds a write: it must vanish
    cpu_q.delete();
    while (req_active) run_cycle();
    cpu_push(1, 10, 8'h5A);
    waited = 0;
    while (!m_pend && waited < 20) begin run_cycle(); waited++; end
    check("accept_timeout", 32'(m_pend), 32'd1);
    nreset = 0;
    req_active = 0;
    cpu_if.cpu_req = 0;
    model_reset();
    repeat (2) @(negedge clk);
    do_checks();
    nreset = 1;
    repeat (40) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
